// File: rtl/capi_mmio_pkg.sv
// Shared types and helpers for the PSL-side MMIO initiator.
package capi_mmio_pkg;

    localparam int MMIO_AD_W   = 24;
    localparam int MMIO_DATA_W = 64;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_WAIT_ACK,
        ST_RESP
    } state_t;

    function automatic logic mmio_parity(input logic [0:MMIO_DATA_W-1] data, input logic odd);
        return (^data) ^ odd;
    endfunction

endpackage

// File: rtl/parity.sv
// Generic parity generator; narrower inputs are zero-extended, which leaves parity unchanged.
module parity
    import capi_mmio_pkg::*;
#(
    parameter int W = MMIO_DATA_W
) (
    input  logic [0:W-1] data,
    input  logic         odd,
    output logic         par
);

    assign par = mmio_parity(MMIO_DATA_W'(data), odd);

endmodule

// File: rtl/capi_mmio_initiator.sv
// Host-side PSL MMIO initiator: one request in, one ha_mm* transaction out, one response back.
// Handshakes: a transfer happens on a cycle where valid && ready; valid is held until it does.
module capi_mmio_initiator
    import capi_mmio_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                   ha_pclock,
    input  logic                   reset_n,
    input  logic                   odd_parity,
    input  logic                   req_valid,
    output logic                   req_ready,
    input  logic                   req_cfg,
    input  logic                   req_rnw,
    input  logic                   req_dw,
    input  logic [0:MMIO_AD_W-1]   req_ad,
    input  logic [0:MMIO_DATA_W-1] req_data,
    output logic                   ha_mmval,
    output logic                   ha_mmcfg,
    output logic                   ha_mmrnw,
    output logic                   ha_mmdw,
    output logic [0:MMIO_AD_W-1]   ha_mmad,
    output logic                   ha_mmadpar,
    output logic [0:MMIO_DATA_W-1] ha_mmdata,
    output logic                   ha_mmdatapar,
    input  logic                   ah_mmack,
    input  logic [0:MMIO_DATA_W-1] ah_mmdata,
    input  logic                   ah_mmdatapar,
    output logic                   rsp_valid,
    input  logic                   rsp_ready,
    output logic [0:MMIO_DATA_W-1] rsp_data,
    output logic                   rsp_parerr,
    output logic                   rsp_timeout,
    output logic                   spurious_ack
);

    localparam int               CNT_W    = $clog2(TIMEOUT_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    state_t                 state;
    logic [CNT_W-1:0]       cnt;
    logic [0:MMIO_DATA_W-1] wdata;
    logic                   ad_par;
    logic                   wd_par;
    logic                   rd_par;

    assign req_ready = (state == ST_IDLE);

    // Reads drive zero data; 32-bit writes replicate the low word onto both lanes.
    assign wdata = req_rnw ? '0 :
                   req_dw  ? req_data :
                             {req_data[32:63], req_data[32:63]};

    parity #(.W(MMIO_AD_W))   u_ad_par (.data(req_ad),    .odd(odd_parity), .par(ad_par));
    parity #(.W(MMIO_DATA_W)) u_wd_par (.data(wdata),     .odd(odd_parity), .par(wd_par));
    parity #(.W(MMIO_DATA_W)) u_rd_par (.data(ah_mmdata), .odd(odd_parity), .par(rd_par));

    always_ff @(posedge ha_pclock) begin
        if (!reset_n) begin
            state        <= ST_IDLE;
            cnt          <= '0;
            ha_mmval     <= 1'b0;
            ha_mmcfg     <= 1'b0;
            ha_mmrnw     <= 1'b0;
            ha_mmdw      <= 1'b0;
            ha_mmad      <= '0;
            ha_mmadpar   <= odd_parity;
            ha_mmdata    <= '0;
            ha_mmdatapar <= odd_parity;
            rsp_valid    <= 1'b0;
            rsp_data     <= '0;
            rsp_parerr   <= 1'b0;
            rsp_timeout  <= 1'b0;
            spurious_ack <= 1'b0;
        end else begin
            if (ah_mmack && state != ST_WAIT_ACK) begin
                spurious_ack <= 1'b1;
            end
            case (state)
                ST_IDLE: begin
                    if (req_valid) begin
                        ha_mmval     <= 1'b1;
                        ha_mmcfg     <= req_cfg;
                        ha_mmrnw     <= req_rnw;
                        ha_mmdw      <= req_dw;
                        ha_mmad      <= req_ad;
                        ha_mmadpar   <= ad_par;
                        ha_mmdata    <= wdata;
                        ha_mmdatapar <= wd_par;
                        state        <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    ha_mmval <= 1'b0;
                    cnt      <= '0;
                    state    <= ST_WAIT_ACK;
                end
                ST_WAIT_ACK: begin
                    // An ack in the final counted cycle still beats the timeout.
                    if (ah_mmack) begin
                        rsp_valid   <= 1'b1;
                        rsp_timeout <= 1'b0;
                        rsp_parerr  <= ha_mmrnw && (rd_par != ah_mmdatapar);
                        rsp_data    <= !ha_mmrnw   ? '0 :
                                       ha_mmdw     ? ah_mmdata :
                                       ha_mmad[23] ? {32'h0, ah_mmdata[32:63]} :
                                                     {32'h0, ah_mmdata[0:31]};
                        state       <= ST_RESP;
                    end else if (cnt == CNT_LAST) begin
                        rsp_valid   <= 1'b1;
                        rsp_timeout <= 1'b1;
                        rsp_parerr  <= 1'b0;
                        rsp_data    <= '0;
                        state       <= ST_RESP;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                ST_RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        state     <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule
